// File: rtl/laser_cover_scorer_if.sv
// Frame snoop, engine DONE/centre capture and scored-result port for laser_cover_scorer.
// RES_VALID/RES_READY: a result transfers on a rising CLK edge where both are high; while
// RES_VALID is high and RES_READY low, SCORE/CNT1/CNT2 stay stable and RES_VALID stays high.
interface laser_cover_scorer_if #(
  parameter int CW = 6
);
  logic          PT_VALID;
  logic [3:0]    X;
  logic [3:0]    Y;
  logic          DONE_IN;
  logic [3:0]    C1X;
  logic [3:0]    C1Y;
  logic [3:0]    C2X;
  logic [3:0]    C2Y;
  logic          RES_READY;
  logic          RES_VALID;
  logic [CW-1:0] SCORE;
  logic [CW-1:0] CNT1;
  logic [CW-1:0] CNT2;
  logic          BUSY;
  logic          ERR;

  modport master (
    output PT_VALID, X, Y, DONE_IN, C1X, C1Y, C2X, C2Y, RES_READY,
    input  RES_VALID, SCORE, CNT1, CNT2, BUSY, ERR
  );

  modport slave (
    input  PT_VALID, X, Y, DONE_IN, C1X, C1Y, C2X, C2Y, RES_READY,
    output RES_VALID, SCORE, CNT1, CNT2, BUSY, ERR
  );
endinterface

// File: rtl/laser_cover_scorer.sv
// Buffers one frame of points, latches the engine's two circle centres on DONE rising,
// then counts covered points one per cycle and presents the counts on a valid/ready port.
module laser_cover_scorer #(
  parameter int NPTS = 40,
  parameter int R2   = 16,
  parameter int CW   = 6
) (
  input  logic                 CLK,
  input  logic                 RST,
  laser_cover_scorer_if.slave  bus,
  output logic [1:0]           state_o
);
  localparam int IW = $clog2(NPTS);

  typedef enum logic [1:0] {CAPTURE, WAIT_DONE, EVAL, HOLD} state_t;

  state_t        state_q, state_d;
  logic [IW-1:0] idx_q, idx_d;
  logic          done_q;
  logic          done_rise;
  logic          wr_en;
  logic [7:0]    buf_q [NPTS];
  logic [3:0]    c1x_q, c1y_q, c2x_q, c2y_q;
  logic [3:0]    c1x_d, c1y_d, c2x_d, c2y_d;
  logic [CW-1:0] cnt1_q, cnt2_q, score_q;
  logic [CW-1:0] cnt1_d, cnt2_d, score_d;
  logic          hit_v_q, hit_last_q, hit1_q, hit2_q;
  logic          hit_v_d, hit_last_d, hit1_d, hit2_d;
  logic          err_q, err_d;
  logic [3:0]    px, py;
  logic          in1, in2;

  function automatic logic covered(input logic [3:0] ax, ay, cx, cy);
    logic [3:0] dx, dy;
    logic [7:0] sx, sy;
    logic [8:0] sum;
    dx  = (ax >= cx) ? ax - cx : cx - ax;
    dy  = (ay >= cy) ? ay - cy : cy - ay;
    sx  = {4'b0, dx} * {4'b0, dx};
    sy  = {4'b0, dy} * {4'b0, dy};
    sum = {1'b0, sx} + {1'b0, sy};
    return sum <= 9'(R2);
  endfunction

  assign done_rise = bus.DONE_IN & ~done_q;
  assign px  = buf_q[idx_q][7:4];
  assign py  = buf_q[idx_q][3:0];
  assign in1 = covered(px, py, c1x_q, c1y_q);
  assign in2 = covered(px, py, c2x_q, c2y_q);

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    wr_en      = 1'b0;
    err_d      = 1'b0;
    c1x_d      = c1x_q;
    c1y_d      = c1y_q;
    c2x_d      = c2x_q;
    c2y_d      = c2y_q;
    cnt1_d     = cnt1_q;
    cnt2_d     = cnt2_q;
    score_d    = score_q;
    hit_v_d    = 1'b0;
    hit_last_d = 1'b0;
    hit1_d     = 1'b0;
    hit2_d     = 1'b0;
    // Compare results are registered one cycle before they are accumulated.
    if (hit_v_q) begin
      cnt1_d  = cnt1_q + {{(CW-1){1'b0}}, hit1_q};
      cnt2_d  = cnt2_q + {{(CW-1){1'b0}}, hit2_q};
      score_d = score_q + {{(CW-1){1'b0}}, hit1_q | hit2_q};
    end
    case (state_q)
      CAPTURE: begin
        if (done_rise) begin
          err_d = 1'b1;
          idx_d = '0;
        end else if (bus.PT_VALID) begin
          wr_en = 1'b1;
          if (idx_q == IW'(NPTS - 1)) begin
            idx_d   = '0;
            state_d = WAIT_DONE;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      WAIT_DONE: begin
        if (done_rise) begin
          c1x_d   = bus.C1X;
          c1y_d   = bus.C1Y;
          c2x_d   = bus.C2X;
          c2y_d   = bus.C2Y;
          cnt1_d  = '0;
          cnt2_d  = '0;
          score_d = '0;
          idx_d   = '0;
          state_d = EVAL;
        end
      end
      EVAL: begin
        if (hit_last_q) begin
          state_d = HOLD;
        end else begin
          hit_v_d    = 1'b1;
          hit1_d     = in1;
          hit2_d     = in2;
          hit_last_d = (idx_q == IW'(NPTS - 1));
          idx_d      = hit_last_d ? '0 : idx_q + 1'b1;
        end
      end
      HOLD: begin
        if (bus.RES_READY) begin
          idx_d   = '0;
          state_d = CAPTURE;
        end
      end
      default: state_d = CAPTURE;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q    <= CAPTURE;
      idx_q      <= '0;
      done_q     <= 1'b1;
      err_q      <= 1'b0;
      c1x_q      <= '0;
      c1y_q      <= '0;
      c2x_q      <= '0;
      c2y_q      <= '0;
      cnt1_q     <= '0;
      cnt2_q     <= '0;
      score_q    <= '0;
      hit_v_q    <= 1'b0;
      hit_last_q <= 1'b0;
      hit1_q     <= 1'b0;
      hit2_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      done_q     <= bus.DONE_IN;
      err_q      <= err_d;
      c1x_q      <= c1x_d;
      c1y_q      <= c1y_d;
      c2x_q      <= c2x_d;
      c2y_q      <= c2y_d;
      cnt1_q     <= cnt1_d;
      cnt2_q     <= cnt2_d;
      score_q    <= score_d;
      hit_v_q    <= hit_v_d;
      hit_last_q <= hit_last_d;
      hit1_q     <= hit1_d;
      hit2_q     <= hit2_d;
    end
  end

  always_ff @(posedge CLK) begin
    if (wr_en) buf_q[idx_q] <= {bus.X, bus.Y};
  end

  assign bus.RES_VALID = (state_q == HOLD);
  assign bus.SCORE     = score_q;
  assign bus.CNT1      = cnt1_q;
  assign bus.CNT2      = cnt2_q;
  assign bus.BUSY      = (state_q != CAPTURE);
  assign bus.ERR       = err_q;
  assign state_o       = state_q;
endmodule

// File: tb/tb_laser_cover_scorer.sv
// Bench for laser_cover_scorer: directed boundary frames plus random frames, scored by a
// geometric model of circle coverage and compared against every presented result.
module tb_laser_cover_scorer;
  localparam int NPTS = 40;
  localparam int CW   = 6;
  localparam int R2   = 16;

  logic CLK = 1'b0;
  logic RST;
  logic [1:0] dbg_state;

  always #5 CLK = ~CLK;

  laser_cover_scorer_if #(.CW(CW)) bus ();

  laser_cover_scorer #(.NPTS(NPTS), .R2(R2), .CW(CW)) dut (
    .CLK     (CLK),
    .RST     (RST),
    .bus     (bus),
    .state_o (dbg_state)
  );

  int total = 0;
  int bad = 0;
  int err_seen = 0;
  int err_exp = 0;
  logic [3*CW-1:0] exp_q[$];
  int fx[NPTS];
  int fy[NPTS];

  task automatic check(input string name, input int act, input int req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s: got %0d, required %0d", name, act, req);
    end
  endtask

  // Coverage by plain Euclidean distance on the current frame.
  function automatic logic [3*CW-1:0] model(input int c1x, c1y, c2x, c2y);
    int n1, n2, nu;
    bit a, b;
    n1 = 0; n2 = 0; nu = 0;
    for (int i = 0; i < NPTS; i++) begin
      a = ((fx[i]-c1x)*(fx[i]-c1x) + (fy[i]-c1y)*(fy[i]-c1y)) <= R2;
      b = ((fx[i]-c2x)*(fx[i]-c2x) + (fy[i]-c2y)*(fy[i]-c2y)) <= R2;
      n1 += int'(a);
      n2 += int'(b);
      nu += int'(a | b);
    end
    return {CW'(nu), CW'(n1), CW'(n2)};
  endfunction

  task automatic pin_model(input string name, input int c1x, c1y, c2x, c2y,
                           input int s, n1, n2);
    logic [3*CW-1:0] m;
    m = model(c1x, c1y, c2x, c2y);
    check({name, "_model_score"}, int'(m[3*CW-1:2*CW]), s);
    check({name, "_model_cnt1"},  int'(m[2*CW-1:CW]), n1);
    check({name, "_model_cnt2"},  int'(m[CW-1:0]), n2);
  endtask

  // Compare process: every presented result must match the front expectation.
  initial begin
    logic [3*CW-1:0] e;
    forever begin
      @(negedge CLK);
      #1;
      if (RST !== 1'b1) begin
        if (bus.ERR) err_seen++;
        if (bus.RES_VALID) begin
          if (exp_q.size() == 0) begin
            check("unexpected_result", 1, 0);
          end else begin
            e = exp_q[0];
            check("score", int'(bus.SCORE), int'(e[3*CW-1:2*CW]));
            check("cnt1",  int'(bus.CNT1),  int'(e[2*CW-1:CW]));
            check("cnt2",  int'(bus.CNT2),  int'(e[CW-1:0]));
            check("busy_while_valid", int'(bus.BUSY), 1);
            check("union_bounds", int'(bus.SCORE >= bus.CNT1 && bus.SCORE >= bus.CNT2 &&
                  int'(bus.SCORE) <= int'(bus.CNT1) + int'(bus.CNT2)), 1);
            if (bus.RES_READY) void'(exp_q.pop_front());
          end
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic send_points(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge CLK);
      bus.PT_VALID = 1'b1;
      bus.X = 4'(fx[i]);
      bus.Y = 4'(fy[i]);
      if ($urandom_range(0, 3) == 0) begin
        @(negedge CLK);
        bus.PT_VALID = 1'b0;
        bus.X = 4'($urandom);
      end
    end
    @(negedge CLK);
    bus.PT_VALID = 1'b0;
  endtask

  task automatic random_frame();
    int cx, cy;
    cx = $urandom_range(0, 15);
    cy = $urandom_range(0, 15);
    for (int i = 0; i < NPTS; i++) begin
      if ($urandom_range(0, 1) == 0) begin
        fx[i] = (cx + $urandom_range(0, 8) + 12) % 16;
        fy[i] = (cy + $urandom_range(0, 8) + 12) % 16;
      end else begin
        fx[i] = $urandom_range(0, 15);
        fy[i] = $urandom_range(0, 15);
      end
    end
  endtask

  task automatic score_frame(input int c1x, c1y, c2x, c2y, input int hold_cycles,
                             output int lat);
    @(negedge CLK);
    bus.DONE_IN  = 1'b0;
    bus.PT_VALID = 1'b1;
    bus.X = 4'($urandom);
    bus.Y = 4'($urandom);
    @(negedge CLK);
    bus.PT_VALID  = 1'b0;
    bus.DONE_IN   = 1'b1;
    bus.C1X = 4'(c1x); bus.C1Y = 4'(c1y);
    bus.C2X = 4'(c2x); bus.C2Y = 4'(c2y);
    bus.RES_READY = (hold_cycles == 0);
    exp_q.push_back(model(c1x, c1y, c2x, c2y));
    @(posedge CLK);
    lat = -1;
    for (int n = 1; n <= 200; n++) begin
      @(posedge CLK);
      #1;
      if (n == 1) begin
        bus.DONE_IN = 1'b0;
        bus.C1X = 4'($urandom);
        bus.C2Y = 4'($urandom);
      end
      if (bus.RES_VALID) begin
        lat = n;
        break;
      end
    end
    check("result_timeout", int'(lat > 0), 1);
    if (lat > 0) begin
      for (int k = 0; k < hold_cycles; k++) begin
        @(negedge CLK);
        #2;
        check("hold_valid", int'(bus.RES_VALID), 1);
        check("hold_busy", int'(bus.BUSY), 1);
      end
      @(negedge CLK);
      bus.RES_READY = 1'b1;
      @(posedge CLK);
      #1;
      check("back_to_capture", int'(bus.BUSY), 0);
      check("valid_dropped", int'(bus.RES_VALID), 0);
    end
  endtask

  initial begin
    int lat;
    RST = 1'b1;
    bus.PT_VALID = 1'b0; bus.X = '0; bus.Y = '0;
    bus.DONE_IN = 1'b1;
    bus.C1X = '0; bus.C1Y = '0; bus.C2X = '0; bus.C2Y = '0;
    bus.RES_READY = 1'b1;
    repeat (3) @(negedge CLK);
    RST = 1'b0;
    @(posedge CLK);
    #1;
    check("rst_res_valid", int'(bus.RES_VALID), 0);
    check("rst_busy", int'(bus.BUSY), 0);
    check("rst_err", int'(bus.ERR), 0);
    check("rst_score", int'(bus.SCORE), 0);
    check("rst_cnt1", int'(bus.CNT1), 0);
    check("rst_cnt2", int'(bus.CNT2), 0);

    // T5: DONE high out of reset is no edge; a real rise after 25 points is an error.
    random_frame();
    send_points(25);
    repeat (2) @(negedge CLK);
    check("t5_no_err_from_level", err_seen, 0);
    bus.DONE_IN = 1'b0;
    @(negedge CLK);
    bus.DONE_IN  = 1'b1;
    bus.PT_VALID = 1'b1;
    bus.X = 4'd7; bus.Y = 4'd9;
    err_exp++;
    @(posedge CLK);
    #1;
    bus.PT_VALID = 1'b0;
    check("t5_err_pulse", int'(bus.ERR), 1);
    check("t5_busy", int'(bus.BUSY), 0);
    @(posedge CLK);
    #1;
    check("t5_err_one_cycle", int'(bus.ERR), 0);
    random_frame();
    send_points(NPTS);
    score_frame(5, 5, 11, 10, 0, lat);

    // T1
    for (int i = 0; i < NPTS; i++) begin fx[i] = 3; fy[i] = 3; end
    pin_model("t1", 3, 3, 12, 12, 40, 40, 0);
    send_points(NPTS);
    score_frame(3, 3, 12, 12, 0, lat);
    check("t1_latency", lat, NPTS + 1);

    // T2
    for (int i = 0; i < NPTS; i++) begin
      fx[i] = (i < 20) ? 0 : 15;
      fy[i] = fx[i];
    end
    pin_model("t2", 2, 2, 13, 13, 40, 20, 20);
    send_points(NPTS);
    score_frame(2, 2, 13, 13, 0, lat);

    // T3: radius-boundary points around (8,8)
    for (int i = 0; i < NPTS; i++) begin fx[i] = 0; fy[i] = 15; end
    fx[3] = 12; fy[3] = 8;
    fx[9] = 11; fy[9] = 10;
    fx[17] = 8; fy[17] = 4;
    fx[22] = 11; fy[22] = 11;
    fx[39] = 12; fy[39] = 9;
    pin_model("t3", 8, 8, 0, 0, 3, 3, 0);
    send_points(NPTS);
    score_frame(8, 8, 0, 0, 0, lat);

    // T4: identical circles
    for (int i = 0; i < NPTS; i++) begin
      fx[i] = (i < 10) ? 4 : 15;
      fy[i] = (i < 10) ? 6 : 0;
    end
    pin_model("t4", 5, 5, 5, 5, 10, 10, 10);
    send_points(NPTS);
    score_frame(5, 5, 5, 5, 0, lat);

    // T6: consumer stalls for 7 cycles
    random_frame();
    send_points(NPTS);
    score_frame($urandom_range(0, 15), $urandom_range(0, 15),
                $urandom_range(0, 15), $urandom_range(0, 15), 7, lat);

    for (int r = 0; r < 6; r++) begin
      random_frame();
      send_points(NPTS);
      score_frame($urandom_range(0, 15), $urandom_range(0, 15),
                  $urandom_range(0, 15), $urandom_range(0, 15),
                  $urandom_range(0, 3), lat);
    end

    // Asynchronous reset in the middle of evaluation
    random_frame();
    send_points(NPTS);
    @(negedge CLK);
    bus.DONE_IN = 1'b1;
    @(posedge CLK);
    repeat (10) @(posedge CLK);
    #2;
    check("mid_eval_busy", int'(bus.BUSY), 1);
    RST = 1'b1;
    #1;
    check("async_rst_valid", int'(bus.RES_VALID), 0);
    check("async_rst_busy", int'(bus.BUSY), 0);
    @(posedge CLK);
    #1;
    check("rst_next_valid", int'(bus.RES_VALID), 0);
    check("rst_next_busy", int'(bus.BUSY), 0);
    check("rst_next_score", int'(bus.SCORE), 0);
    @(negedge CLK);
    bus.DONE_IN = 1'b0;
    RST = 1'b0;

    random_frame();
    send_points(NPTS);
    score_frame($urandom_range(0, 15), $urandom_range(0, 15),
                $urandom_range(0, 15), $urandom_range(0, 15), 1, lat);

    repeat (3) @(negedge CLK);
    check("err_pulses", err_seen, err_exp);
    check("queue_drained", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
